mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port and a data port. Data requests normally win; a starvation counter
// forces a fetch grant after STARVE_LIMIT consecutive data grants made while
// a fetch was waiting. A BUSY-cycle watchdog aborts a transaction that gets no
// mem_ack within TIMEOUT cycles, returns zero data and sets a sticky err.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   if_req/if_addr        fetch request and byte address (in)
//   if_rdata/if_ready     fetched word and one-cycle completion pulse (out)
//   dm_req/dm_we/dm_addr/dm_wdata   data request, direction, address, store data (in)
//   dm_rdata/dm_ready     load data and one-cycle completion pulse (out)
//   mem_req/mem_we/mem_addr/mem_wdata   request to the memory (out)
//   mem_ack/mem_rdata     memory completion and read data, same cycle (in)
//   err                   sticky timeout flag (out)
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);
    localparam int unsigned TW = $clog2(TIMEOUT + 2);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [DW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
    logic            if_ready_q, if_ready_d;
    logic            dm_ready_q, dm_ready_d;
    logic            err_q, err_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic            fetch_win_c;
    logic            tmo_hit_c;
    logic [DW-1:0]   rsp_data_c;

    // Fetch wins when it is alone, or when it has waited out STARVE_LIMIT data grants
    assign fetch_win_c = if_req && (!dm_req || (starve_q == STARVE_MAX));
    assign tmo_hit_c   = (tmo_q == TMO_LAST);
    // An aborted transaction returns zero; a real ack wins over a same-cycle timeout
    assign rsp_data_c  = mem_ack ? mem_rdata : '0;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            starve_q    <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            err_q       <= err_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        err_d       = err_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;

        case (state_q)
            IDLE: begin
                if (fetch_win_c) begin
                    state_d     = BUSY_I;
                    mem_addr_d  = if_addr;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                    tmo_d       = '0;
                end else if (dm_req) begin
                    state_d     = BUSY_D;
                    mem_addr_d  = dm_addr;
                    mem_we_d    = dm_we;
                    mem_wdata_d = dm_wdata;
                    tmo_d       = '0;
                    if (if_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || tmo_hit_c) begin
                    state_d  = DONE;
                    mem_we_d = 1'b0;
                    if (!mem_ack) begin
                        err_d = 1'b1;
                    end
                    if (state_q == BUSY_I) begin
                        if_rdata_d = rsp_data_c;
                        if_ready_d = 1'b1;
                    end else begin
                        dm_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = rsp_data_c;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DONE: begin
                // One dead cycle so the requester can retire its request first
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_req_d = (state_d == BUSY_I) || (state_d == BUSY_D);
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester agents, a memory model with programmable
// ack delay, and scoreboards for grant order and returned data.
module tb_mem_arbiter;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    logic        ack_m;
    logic [31:0] rdata_m;
    logic        stray;

    assign mem_ack   = ack_m | stray;
    assign mem_rdata = stray ? 32'hDEAD_BEEF : rdata_m;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fetch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;     // expected BUSY length, 0 = unchecked
    } grant_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    grant_t      grant_q[$];
    logic [31:0] if_exp[$];
    logic [31:0] dm_exp[$];
    logic [31:0] if_pend[$];
    dreq_t       dm_pend[$];
    logic [31:0] mem [logic [31:0]];

    int          n_chk = 0;
    int          n_err = 0;
    int          waits = 0;
    int          wcnt  = 0;
    logic [31:0] dm_last = '0;

    logic        prev_req = 1'b0;
    logic        in_txn = 1'b0;
    int          cyc = 0;
    grant_t      cur;
    logic        if_busy = 1'b0;
    logic        dm_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    // Monitor, requester agents and memory model, in that fixed order
    always @(negedge clk) begin
        if (!reset) begin
            prev_req = 1'b0;
            in_txn   = 1'b0;
            if_busy  = 1'b0;
            dm_busy  = 1'b0;
            if_req   = 1'b0;
            dm_req   = 1'b0;
            ack_m    = 1'b0;
            wcnt     = 0;
        end else begin
            if (mem_req && !prev_req) begin
                if (grant_q.size() == 0) begin
                    chk("grant_unexp", 32'(mem_req), 0);
                end else begin
                    cur    = grant_q.pop_front();
                    cyc    = 0;
                    in_txn = 1'b1;
                    chk(cur.fetch ? "grant_fetch_addr" : "grant_data_addr", mem_addr, cur.addr);
                end
            end
            if (mem_req && in_txn) begin
                cyc++;
                chk("busy_addr", mem_addr, cur.addr);
                chk("busy_we", 32'(mem_we), 32'(cur.we));
                if (cur.we) chk("busy_wdata", mem_wdata, cur.wdata);
            end
            if (!mem_req && prev_req && in_txn) begin
                if (cur.cyc != 0) chk("busy_cycles", 32'(cyc), 32'(cur.cyc));
                chk("ready_at_end", 32'(cur.fetch ? if_ready : dm_ready), 1);
                chk("other_ready", 32'(cur.fetch ? dm_ready : if_ready), 0);
                chk("we_after", 32'(mem_we), 0);
                in_txn = 1'b0;
            end
            if (if_ready) begin
                if (if_exp.size() == 0) chk("if_unexp", 32'(if_ready), 0);
                else chk("if_rdata", if_rdata, if_exp.pop_front());
            end
            if (dm_ready) begin
                if (dm_exp.size() == 0) chk("dm_unexp", 32'(dm_ready), 0);
                else chk("dm_rdata", dm_rdata, dm_exp.pop_front());
            end
            prev_req = mem_req;

            if (if_ready) if_busy = 1'b0;
            if (!if_busy) begin
                if (if_pend.size() != 0) begin
                    if_addr = if_pend.pop_front();
                    if_req  = 1'b1;
                    if_busy = 1'b1;
                end else begin
                    if_req = 1'b0;
                end
            end
            if (dm_ready) dm_busy = 1'b0;
            if (!dm_busy) begin
                if (dm_pend.size() != 0) begin
                    dreq_t d;
                    d        = dm_pend.pop_front();
                    dm_we    = d.we;
                    dm_addr  = d.addr;
                    dm_wdata = d.wdata;
                    dm_req   = 1'b1;
                    dm_busy  = 1'b1;
                end else begin
                    dm_req = 1'b0;
                end
            end

            if (mem_req) begin
                if (wcnt == waits) begin
                    ack_m   = 1'b1;
                    rdata_m = rd_fn(mem_addr);
                    if (mem_we) mem[mem_addr] = mem_wdata;
                end else begin
                    ack_m = 1'b0;
                end
                wcnt++;
            end else begin
                ack_m = 1'b0;
                wcnt  = 0;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input logic f, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input int c);
        grant_t g;
        g.fetch = f; g.we = we; g.addr = a; g.wdata = wd; g.cyc = c;
        grant_q.push_back(g);
    endtask

    task automatic req_if(input logic [31:0] a, input logic [31:0] e);
        if_pend.push_back(a);
        if_exp.push_back(e);
    endtask

    task automatic req_dm_rd(input logic [31:0] a, input logic [31:0] e);
        dreq_t d;
        d.we = 1'b0; d.addr = a; d.wdata = '0;
        dm_pend.push_back(d);
        dm_exp.push_back(e);
        dm_last = e;
    endtask

    task automatic req_dm_wr(input logic [31:0] a, input logic [31:0] wd);
        dreq_t d;
        d.we = 1'b1; d.addr = a; d.wdata = wd;
        dm_pend.push_back(d);
        dm_exp.push_back(dm_last);
    endtask

    task automatic wait_quiet(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (if_pend.size() == 0 && dm_pend.size() == 0 && !if_busy && !dm_busy &&
                !mem_req && grant_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 1);
        sync();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; stray = 1'b0; ack_m = 1'b0; rdata_m = '0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_readys", {30'd0, if_ready, dm_ready}, 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b1;
        sync();

        // Minimum-latency fetch
        mem[32'h40] = 32'h8C02_0004;
        waits = 0;
        exp_grant(1'b1, 1'b0, 32'h40, '0, 1);
        req_if(32'h40, 32'h8C02_0004);
        wait_quiet("q_fetch");

        // Ack while idle must be ignored
        stray = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ready", {30'd0, if_ready, dm_ready}, 0);
            chk("stray_req", 32'(mem_req), 0);
        end
        sync();
        stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_if_hold", if_rdata, 32'h8C02_0004);
        chk("stray_dm_hold", dm_rdata, 0);
        sync();

        // Simultaneous requests: data first, fetch at the next IDLE
        waits = 1;
        exp_grant(1'b0, 1'b0, 32'h200, '0, 2);
        exp_grant(1'b1, 1'b0, 32'h44, '0, 2);
        req_dm_rd(32'h200, rd_fn(32'h200));
        req_if(32'h44, rd_fn(32'h44));
        wait_quiet("q_both");

        // Continuous data traffic: fetch forced in after 4 data grants, then the count restarts
        waits = 0;
        for (int k = 0; k < 9; k++) begin
            if (k == 4) exp_grant(1'b1, 1'b0, 32'h80, '0, 1);
            if (k == 8) exp_grant(1'b1, 1'b0, 32'h84, '0, 1);
            exp_grant(1'b0, 1'b0, 32'h300 + 32'(4 * k), '0, 1);
            req_dm_rd(32'h300 + 32'(4 * k), rd_fn(32'h300 + 32'(4 * k)));
        end
        req_if(32'h80, rd_fn(32'h80));
        req_if(32'h84, rd_fn(32'h84));
        wait_quiet("q_starve");

        // Write with 3 ack waits leaves dm_rdata untouched
        waits = 3;
        exp_grant(1'b0, 1'b1, 32'h100, 32'hCAFE_0001, 4);
        req_dm_wr(32'h100, 32'hCAFE_0001);
        wait_quiet("q_write");
        waits = 0;
        exp_grant(1'b0, 1'b0, 32'h100, '0, 1);
        req_dm_rd(32'h100, 32'hCAFE_0001);
        wait_quiet("q_readback");

        // No ack: abort after TMO cycles, zero data, sticky err
        chk("err_before", 32'(err), 0);
        waits = 1000;
        exp_grant(1'b1, 1'b0, 32'h48, '0, TMO);
        req_if(32'h48, 32'h0);
        wait_quiet("q_timeout");
        chk("err_set", 32'(err), 1);
        waits = 2;
        exp_grant(1'b1, 1'b0, 32'h4C, '0, 3);
        req_if(32'h4C, rd_fn(32'h4C));
        wait_quiet("q_after_to");
        chk("err_sticky", 32'(err), 1);

        // Reset during a data transaction
        waits = 1000;
        exp_grant(1'b0, 1'b0, 32'h204, '0, 0);
        begin
            dreq_t d;
            d.we = 1'b0; d.addr = 32'h204; d.wdata = '0;
            dm_pend.push_back(d);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        chk("rst_txn_busy", 32'(mem_req), 1);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_req", 32'(mem_req), 0);
        dm_pend.delete();
        repeat (2) @(negedge clk);
        chk("rst_txn_ready", {30'd0, if_ready, dm_ready}, 0);
        chk("rst_txn_err", 32'(err), 0);
        chk("rst_txn_if_rdata", if_rdata, 0);
        reset = 1'b1;
        waits = 0;
        sync();
        exp_grant(1'b1, 1'b0, 32'h50, '0, 1);
        req_if(32'h50, rd_fn(32'h50));
        wait_quiet("q_post_rst");

        chk("sb_left", 32'(grant_q.size() + if_exp.size() + dm_exp.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
